bram_port_arbiter: RTL and testbench

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_bram_port_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter that maps up to two of NUM_REQ requesters per cycle onto
// the A and B ports of a dual-port BRAM and routes the BRAM output back one cycle later.
module bram_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 128,
  localparam int AW = $clog2(RAM_DEPTH),
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_we,
  input  logic [NUM_REQ*AW-1:0]         i_req_addr,
  input  logic [NUM_REQ*RAM_WIDTH-1:0]  i_req_din,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [NUM_REQ*RAM_WIDTH-1:0]  o_rsp_data,
  output logic                          o_we_a,
  output logic [AW-1:0]                 o_addr_a,
  output logic [RAM_WIDTH-1:0]          o_din_a,
  input  logic [RAM_WIDTH-1:0]          i_dout_a,
  output logic                          o_we_b,
  output logic [AW-1:0]                 o_addr_b,
  output logic [RAM_WIDTH-1:0]          o_din_b,
  input  logic [RAM_WIDTH-1:0]          i_dout_b
);

  logic [AW-1:0]        req_addr [NUM_REQ];
  logic [RAM_WIDTH-1:0] req_din  [NUM_REQ];

  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] scan_idx;
  logic          cand_a_vld, cand_b_vld;
  logic [IW-1:0] cand_a_idx, cand_b_idx;
  logic          collide;
  logic          grant_a, grant_b;

  logic          vld_a_p0, vld_b_p0;
  logic [IW-1:0] idx_a_p0, idx_b_p0;

  function automatic logic [IW-1:0] wrap_idx(input int s);
    return (s >= NUM_REQ) ? IW'(s - NUM_REQ) : IW'(s);
  endfunction

  function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] idx);
    if (int'(idx) == NUM_REQ - 1) return '0;
    return idx + 1'b1;
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign req_addr[g] = i_req_addr[g*AW +: AW];
    assign req_din[g]  = i_req_din[g*RAM_WIDTH +: RAM_WIDTH];
  end

  // Stage 0: round-robin scan picks the first two valid requesters from rr_ptr
  always_comb begin
    cand_a_vld = 1'b0;
    cand_b_vld = 1'b0;
    cand_a_idx = '0;
    cand_b_idx = '0;
    scan_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = wrap_idx(int'(rr_ptr) + i);
      if (i_req_valid[scan_idx]) begin
        if (!cand_a_vld) begin
          cand_a_vld = 1'b1;
          cand_a_idx = scan_idx;
        end else if (!cand_b_vld) begin
          cand_b_vld = 1'b1;
          cand_b_idx = scan_idx;
        end
      end
    end
  end

  // Two reads may share an address; anything involving a write on one address goes to A alone.
  assign collide = (req_addr[cand_a_idx] == req_addr[cand_b_idx]) &&
                   (i_req_we[cand_a_idx] || i_req_we[cand_b_idx]);
  assign grant_a = cand_a_vld && !RST;
  assign grant_b = cand_b_vld && !collide && !RST;

  always_comb begin
    o_req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_req_ready[k] = (grant_a && cand_a_idx == IW'(k)) ||
                       (grant_b && cand_b_idx == IW'(k));
    end
  end

  always_comb begin
    o_we_a   = 1'b0;
    o_addr_a = '0;
    o_din_a  = '0;
    o_we_b   = 1'b0;
    o_addr_b = '0;
    o_din_b  = '0;
    if (grant_a) begin
      o_we_a   = i_req_we[cand_a_idx];
      o_addr_a = req_addr[cand_a_idx];
      o_din_a  = req_din[cand_a_idx];
    end
    if (grant_b) begin
      o_we_b   = i_req_we[cand_b_idx];
      o_addr_b = req_addr[cand_b_idx];
      o_din_b  = req_din[cand_b_idx];
    end
  end

  // Stage 0 -> 1: pointer advance and port-to-requester mapping for the response
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr   <= '0;
      vld_a_p0 <= 1'b0;
      vld_b_p0 <= 1'b0;
    end else begin
      vld_a_p0 <= grant_a;
      vld_b_p0 <= grant_b;
      if (grant_a) rr_ptr <= ptr_after(grant_b ? cand_b_idx : cand_a_idx);
    end
  end

  always_ff @(posedge CLK) begin
    idx_a_p0 <= cand_a_idx;
    idx_b_p0 <= cand_b_idx;
  end

  // Stage 1: steer BRAM outputs back to the requester that owned each port
  always_comb begin
    o_rsp_valid = '0;
    o_rsp_data  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!RST && vld_a_p0 && idx_a_p0 == IW'(k)) begin
        o_rsp_valid[k] = 1'b1;
        o_rsp_data[k*RAM_WIDTH +: RAM_WIDTH] = i_dout_a;
      end else if (!RST && vld_b_p0 && idx_b_p0 == IW'(k)) begin
        o_rsp_valid[k] = 1'b1;
        o_rsp_data[k*RAM_WIDTH +: RAM_WIDTH] = i_dout_b;
      end
    end
  end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: write-through dual-port BRAM, queue-based arbitration
// model, directed scenarios and a randomized run.
module tb_bram_port_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int D  = 128;
  localparam int AW = 7;
  localparam int PW = 2 * (1 + AW + W);

  logic           CLK = 1'b0;
  logic           RST;
  logic [N-1:0]   i_req_valid, i_req_we;
  logic [N*AW-1:0] i_req_addr;
  logic [N*W-1:0] i_req_din;
  logic [N-1:0]   o_req_ready, o_rsp_valid;
  logic [N*W-1:0] o_rsp_data;
  logic           o_we_a, o_we_b;
  logic [AW-1:0]  o_addr_a, o_addr_b;
  logic [W-1:0]   o_din_a, o_din_b, i_dout_a, i_dout_b;

  bram_port_arbiter #(.NUM_REQ(N), .RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
    .CLK(CLK), .RST(RST),
    .i_req_valid(i_req_valid), .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_din(i_req_din),
    .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data),
    .o_we_a(o_we_a), .o_addr_a(o_addr_a), .o_din_a(o_din_a), .i_dout_a(i_dout_a),
    .o_we_b(o_we_b), .o_addr_b(o_addr_b), .o_din_b(o_din_b), .i_dout_b(i_dout_b)
  );

  always #5 CLK = ~CLK;

  // Write-through dual-port BRAM
  logic [W-1:0] bram [D] = '{default: '0};
  always @(posedge CLK) begin
    if (o_we_a) begin bram[o_addr_a] <= o_din_a; i_dout_a <= o_din_a; end
    else i_dout_a <= bram[o_addr_a];
    if (o_we_b) begin bram[o_addr_b] <= o_din_b; i_dout_b <= o_din_b; end
    else i_dout_b <= bram[o_addr_b];
  end

  // Reference model state
  int           m_ptr = 0;
  logic [W-1:0] ref_mem [D] = '{default: '0};
  logic [N-1:0] pend_v = '0;
  logic [W-1:0] pend_d [N];
  bit           cyc_ga, cyc_gb;
  int           cyc_a, cyc_b;
  logic [N-1:0] exp_ready, exp_rv;
  logic [N*W-1:0] exp_rd;
  logic [PW-1:0]  exp_port;
  logic [AW-1:0]  t_addr [N];
  logic [W-1:0]   t_din  [N];
  int checks = 0;
  int errors = 0;

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] w, input logic r);
    int order[$];
    logic ea, eb;
    logic [AW-1:0] aa, ab;
    logic [W-1:0] da, db;
    RST = r;
    i_req_valid = v;
    i_req_we = w;
    for (int k = 0; k < N; k++) begin
      i_req_addr[k*AW +: AW] = t_addr[k];
      i_req_din[k*W +: W] = t_din[k];
    end
    for (int i = 0; i < N; i++) if (v[(m_ptr + i) % N]) order.push_back((m_ptr + i) % N);
    cyc_ga = !r && order.size() > 0;
    cyc_gb = !r && order.size() > 1;
    cyc_a = cyc_ga ? order[0] : 0;
    cyc_b = cyc_gb ? order[1] : 0;
    if (cyc_gb && t_addr[cyc_a] == t_addr[cyc_b] && (w[cyc_a] || w[cyc_b])) cyc_gb = 0;
    exp_ready = '0;
    if (cyc_ga) exp_ready[cyc_a] = 1'b1;
    if (cyc_gb) exp_ready[cyc_b] = 1'b1;
    ea = cyc_ga && w[cyc_a]; aa = cyc_ga ? t_addr[cyc_a] : AW'(0); da = cyc_ga ? t_din[cyc_a] : W'(0);
    eb = cyc_gb && w[cyc_b]; ab = cyc_gb ? t_addr[cyc_b] : AW'(0); db = cyc_gb ? t_din[cyc_b] : W'(0);
    exp_port = {ea, aa, da, eb, ab, db};
    exp_rv = r ? '0 : pend_v;
    exp_rd = '0;
    for (int k = 0; k < N; k++) if (exp_rv[k]) exp_rd[k*W +: W] = pend_d[k];
    #2;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RST) begin
      m_ptr = 0;
      pend_v = '0;
    end else begin
      pend_v = '0;
      if (cyc_ga) begin
        pend_v[cyc_a] = 1'b1;
        pend_d[cyc_a] = i_req_we[cyc_a] ? t_din[cyc_a] : ref_mem[t_addr[cyc_a]];
      end
      if (cyc_gb) begin
        pend_v[cyc_b] = 1'b1;
        pend_d[cyc_b] = i_req_we[cyc_b] ? t_din[cyc_b] : ref_mem[t_addr[cyc_b]];
      end
      if (cyc_ga && i_req_we[cyc_a]) ref_mem[t_addr[cyc_a]] = t_din[cyc_a];
      if (cyc_gb && i_req_we[cyc_b]) ref_mem[t_addr[cyc_b]] = t_din[cyc_b];
      if (cyc_ga) m_ptr = ((cyc_gb ? cyc_b : cyc_a) + 1) % N;
    end
    #1;
  endtask

  task automatic do_reset();
    drive('0, '0, 1'b1);
    tick();
  endtask

  task automatic test_reset();
    for (int k = 0; k < N; k++) begin t_addr[k] = AW'(k + 1); t_din[k] = $urandom; end
    for (int c = 0; c < 3; c++) begin
      drive(4'b1111, 4'b0101, c < 2);
      checks += 4;
      if (o_req_ready !== exp_ready) begin errors++; $display("FAIL reset_ready got %b want %b", o_req_ready, exp_ready); end
      if ({o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b} !== exp_port) begin errors++; $display("FAIL reset_bram got %h want %h", {o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b}, exp_port); end
      if (o_rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid got %b want 0000", o_rsp_valid); end
      if (o_rsp_data !== '0) begin errors++; $display("FAIL reset_rsp_data got %h want 0", o_rsp_data); end
      if (c < 2) begin
        checks++;
        if (o_req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready_zero got %b want 0000", o_req_ready); end
      end
      tick();
    end
  endtask

  task automatic test_single_read();
    logic [N-1:0] want_rv;
    do_reset();
    t_addr[0] = AW'(5); t_din[0] = 32'hDEADBEEF;
    t_addr[2] = AW'(5); t_din[2] = $urandom;
    for (int c = 0; c < 3; c++) begin
      drive(c == 0 ? 4'b0001 : c == 1 ? 4'b0100 : 4'b0000, c == 0 ? 4'b0001 : 4'b0000, 1'b0);
      checks += 4;
      if (o_req_ready !== exp_ready) begin errors++; $display("FAIL single_ready got %b want %b", o_req_ready, exp_ready); end
      if ({o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b} !== exp_port) begin errors++; $display("FAIL single_bram got %h want %h", {o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b}, exp_port); end
      if (o_rsp_valid !== exp_rv) begin errors++; $display("FAIL single_rsp_valid got %b want %b", o_rsp_valid, exp_rv); end
      if (o_rsp_data !== exp_rd) begin errors++; $display("FAIL single_rsp_data got %h want %h", o_rsp_data, exp_rd); end
      if (c == 1) begin
        checks += 2;
        if (o_req_ready !== 4'b0100) begin errors++; $display("FAIL single_ready2 got %b want 0100", o_req_ready); end
        if (o_addr_a !== AW'(5)) begin errors++; $display("FAIL single_addr_a got %0d want 5", o_addr_a); end
      end
      if (c == 2) begin
        want_rv = 4'b0100;
        checks += 2;
        if (o_rsp_valid !== want_rv) begin errors++; $display("FAIL single_rv2 got %b want %b", o_rsp_valid, want_rv); end
        if (o_rsp_data[2*W +: W] !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data2 got %h want deadbeef", o_rsp_data[2*W +: W]); end
      end
      tick();
    end
  endtask

  task automatic test_dual_grant();
    logic [N-1:0] want_ready, want_rv;
    do_reset();
    for (int k = 0; k < N; k++) begin t_addr[k] = AW'(30 + k); t_din[k] = $urandom; end
    for (int c = 0; c < 3; c++) begin
      drive(c == 0 ? 4'b0011 : c == 1 ? 4'b1111 : 4'b0000, 4'b0000, 1'b0);
      want_ready = (c == 0) ? 4'b0011 : (c == 1) ? 4'b1100 : 4'b0000;
      want_rv = (c == 0) ? 4'b0000 : (c == 1) ? 4'b0011 : 4'b1100;
      checks += 6;
      if (o_req_ready !== exp_ready) begin errors++; $display("FAIL dual_ready got %b want %b", o_req_ready, exp_ready); end
      if ({o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b} !== exp_port) begin errors++; $display("FAIL dual_bram got %h want %h", {o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b}, exp_port); end
      if (o_rsp_valid !== exp_rv) begin errors++; $display("FAIL dual_rsp_valid got %b want %b", o_rsp_valid, exp_rv); end
      if (o_rsp_data !== exp_rd) begin errors++; $display("FAIL dual_rsp_data got %h want %h", o_rsp_data, exp_rd); end
      if (o_req_ready !== want_ready) begin errors++; $display("FAIL dual_pairs got %b want %b", o_req_ready, want_ready); end
      if (o_rsp_valid !== want_rv) begin errors++; $display("FAIL dual_rsp_strobe got %b want %b", o_rsp_valid, want_rv); end
      tick();
    end
  endtask

  task automatic test_conflict();
    do_reset();
    t_addr[0] = AW'(9); t_din[0] = 32'h11;
    t_addr[1] = AW'(9); t_din[1] = $urandom;
    for (int c = 0; c < 3; c++) begin
      drive(c == 0 ? 4'b0011 : c == 1 ? 4'b0010 : 4'b0000, c == 0 ? 4'b0001 : 4'b0000, 1'b0);
      checks += 4;
      if (o_req_ready !== exp_ready) begin errors++; $display("FAIL conflict_ready got %b want %b", o_req_ready, exp_ready); end
      if ({o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b} !== exp_port) begin errors++; $display("FAIL conflict_bram got %h want %h", {o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b}, exp_port); end
      if (o_rsp_valid !== exp_rv) begin errors++; $display("FAIL conflict_rsp_valid got %b want %b", o_rsp_valid, exp_rv); end
      if (o_rsp_data !== exp_rd) begin errors++; $display("FAIL conflict_rsp_data got %h want %h", o_rsp_data, exp_rd); end
      checks++;
      if (c == 0 && o_req_ready !== 4'b0001) begin errors++; $display("FAIL conflict_only_a got %b want 0001", o_req_ready); end
      if (c == 1 && o_req_ready !== 4'b0010) begin errors++; $display("FAIL conflict_retry got %b want 0010", o_req_ready); end
      if (c == 2 && o_rsp_data[W +: W] !== 32'h11) begin errors++; $display("FAIL conflict_data got %h want 00000011", o_rsp_data[W +: W]); end
      tick();
    end
  endtask

  task automatic test_fairness();
    int since [N];
    int worst;
    do_reset();
    for (int k = 0; k < N; k++) begin t_addr[k] = AW'(20 + k); t_din[k] = $urandom; since[k] = 0; end
    worst = 0;
    for (int c = 0; c < 6; c++) begin
      drive(4'b1111, 4'b0000, 1'b0);
      checks += 5;
      if (o_req_ready !== exp_ready) begin errors++; $display("FAIL fair_ready got %b want %b", o_req_ready, exp_ready); end
      if ({o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b} !== exp_port) begin errors++; $display("FAIL fair_bram got %h want %h", {o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b}, exp_port); end
      if (o_rsp_valid !== exp_rv) begin errors++; $display("FAIL fair_rsp_valid got %b want %b", o_rsp_valid, exp_rv); end
      if (o_rsp_data !== exp_rd) begin errors++; $display("FAIL fair_rsp_data got %h want %h", o_rsp_data, exp_rd); end
      if (o_req_ready !== ((c % 2 == 0) ? 4'b0011 : 4'b1100)) begin errors++; $display("FAIL fair_pair got %b cycle %0d", o_req_ready, c); end
      for (int k = 0; k < N; k++) begin
        since[k] = o_req_ready[k] ? 0 : since[k] + 1;
        if (since[k] > worst) worst = since[k];
      end
      tick();
    end
    checks++;
    if (worst > 1) begin errors++; $display("FAIL fair_wait got %0d idle cycles want at most 1", worst); end
  endtask

  task automatic test_same_addr();
    logic [W-1:0] val;
    do_reset();
    val = $urandom;
    for (int k = 0; k < N; k++) begin t_addr[k] = AW'(7); t_din[k] = $urandom; end
    t_din[0] = val;
    for (int c = 0; c < 3; c++) begin
      drive(c == 0 ? 4'b0001 : c == 1 ? 4'b1010 : 4'b0000, c == 0 ? 4'b0001 : 4'b0000, 1'b0);
      checks += 4;
      if (o_req_ready !== exp_ready) begin errors++; $display("FAIL same_ready got %b want %b", o_req_ready, exp_ready); end
      if ({o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b} !== exp_port) begin errors++; $display("FAIL same_bram got %h want %h", {o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b}, exp_port); end
      if (o_rsp_valid !== exp_rv) begin errors++; $display("FAIL same_rsp_valid got %b want %b", o_rsp_valid, exp_rv); end
      if (o_rsp_data !== exp_rd) begin errors++; $display("FAIL same_rsp_data got %h want %h", o_rsp_data, exp_rd); end
      if (c == 1) begin
        checks++;
        if (o_req_ready !== 4'b1010) begin errors++; $display("FAIL same_both got %b want 1010", o_req_ready); end
      end
      if (c == 2) begin
        checks += 2;
        if (o_rsp_valid !== 4'b1010) begin errors++; $display("FAIL same_rv got %b want 1010", o_rsp_valid); end
        if ({o_rsp_data[3*W +: W], o_rsp_data[W +: W]} !== {val, val}) begin errors++; $display("FAIL same_data got %h want %h%h", {o_rsp_data[3*W +: W], o_rsp_data[W +: W]}, val, val); end
      end
      tick();
    end
  endtask

  task automatic test_reset_midstream();
    logic [N-1:0] v;
    logic r;
    do_reset();
    for (int k = 0; k < N; k++) begin t_addr[k] = AW'(40 + k); t_din[k] = $urandom; end
    for (int c = 0; c < 5; c++) begin
      v = (c == 0) ? 4'b0011 : (c == 3) ? 4'b0000 : 4'b1111;
      r = (c == 1 || c == 2);
      drive(v, 4'b0000, r);
      checks += 4;
      if (o_req_ready !== exp_ready) begin errors++; $display("FAIL midrst_ready got %b want %b", o_req_ready, exp_ready); end
      if ({o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b} !== exp_port) begin errors++; $display("FAIL midrst_bram got %h want %h", {o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b}, exp_port); end
      if (o_rsp_valid !== exp_rv) begin errors++; $display("FAIL midrst_rsp_valid got %b want %b", o_rsp_valid, exp_rv); end
      if (o_rsp_data !== exp_rd) begin errors++; $display("FAIL midrst_rsp_data got %h want %h", o_rsp_data, exp_rd); end
      checks++;
      if (c >= 1 && c <= 3 && o_rsp_valid !== 4'b0000) begin errors++; $display("FAIL midrst_quiet got %b want 0000 cycle %0d", o_rsp_valid, c); end
      if (c == 4 && o_req_ready !== 4'b0011) begin errors++; $display("FAIL midrst_ptr got %b want 0011", o_req_ready); end
      tick();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] v, w;
    logic r;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin t_addr[k] = AW'($urandom_range(0, 7)); t_din[k] = $urandom; end
      v = N'($urandom);
      w = N'($urandom);
      r = ($urandom_range(0, 39) == 0);
      drive(v, w, r);
      checks += 4;
      if (o_req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready got %b want %b cycle %0d", o_req_ready, exp_ready, c); end
      if ({o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b} !== exp_port) begin errors++; $display("FAIL rand_bram got %h want %h cycle %0d", {o_we_a, o_addr_a, o_din_a, o_we_b, o_addr_b, o_din_b}, exp_port, c); end
      if (o_rsp_valid !== exp_rv) begin errors++; $display("FAIL rand_rsp_valid got %b want %b cycle %0d", o_rsp_valid, exp_rv, c); end
      if (o_rsp_data !== exp_rd) begin errors++; $display("FAIL rand_rsp_data got %h want %h cycle %0d", o_rsp_data, exp_rd, c); end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    i_req_valid = '0;
    i_req_we = '0;
    i_req_addr = '0;
    i_req_din = '0;
    for (int k = 0; k < N; k++) begin t_addr[k] = '0; t_din[k] = '0; pend_d[k] = '0; end
    #1;
    test_reset();
    test_single_read();
    test_dual_grant();
    test_conflict();
    test_fairness();
    test_same_addr();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
